// File: rtl/sbox_pkg.sv
// Shared definitions for the nibble-substitution round sequencer:
// word geometry, the 4-bit substitution table and the FSM state encoding.
package sbox_pkg;

   localparam int W   = 16;   // word width, fixed at four nibbles
   localparam int NIB = 4;    // nibble width
   localparam int RW  = 4;    // width of the round-count input

   // Substitution table S[0..F] = 8,5,2,A,E,8,9,7,5,F,B,4,8,C,1,0.
   // Entry i lives in bits [4i+3:4i], so the literal reads S[F] first.
   localparam logic [63:0] SBOX_TABLE = 64'h01C8_4BF5_798E_A258;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_MIX  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   function automatic logic [NIB-1:0] sbox_lookup(input logic [NIB-1:0] x);
      return SBOX_TABLE[{x, 2'b00} +: NIB];
   endfunction

endpackage

// File: rtl/sbox4.sv
// Purely combinational 4-bit substitution box.
module sbox4
   import sbox_pkg::*;
(
   input  logic [NIB-1:0] x,
   output logic [NIB-1:0] y
);

   // Table lookup; no state.
   always_comb begin
      y = sbox_lookup(x);
   end

endmodule

// File: rtl/sbox_round_ctrl.sv
// Round sequencer: runs a 16-bit word through R rounds of nibble
// substitution (one nibble per clock through a single shared sbox4)
// followed by a 1-bit rotate-left per round.
//
// Handshake: start is only looked at while idle (busy=0); the accept edge
// captures din and rounds. done is a one-cycle pulse and dout is valid in
// that cycle and holds until the next done. start during busy is dropped.
module sbox_round_ctrl
   import sbox_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  din,
   input  logic [RW-1:0] rounds,
   output logic [W-1:0]  dout,
   output logic          busy,
   output logic          done,
   output logic [1:0]    dbg_state
);

   state_t          state;
   logic [W-1:0]    word;
   logic [RW-1:0]   rnds;
   logic [RW-1:0]   rnd_cnt;
   logic [1:0]      nib_cnt;
   logic [NIB-1:0]  sbox_x;
   logic [NIB-1:0]  sbox_y;
   logic [W-1:0]    word_sub;
   logic [W-1:0]    word_rot;
   logic            last_round;

   sbox4 u_sbox4 (
      .x (sbox_x),
      .y (sbox_y)
   );

   // Select the current nibble for the shared sbox and build the
   // substituted / rotated candidates for the word register.
   always_comb begin
      sbox_x     = word[{nib_cnt, 2'b00} +: NIB];
      word_sub   = word;
      word_sub[{nib_cnt, 2'b00} +: NIB] = sbox_y;
      word_rot   = {word[W-2:0], word[W-1]};
      last_round = (rnd_cnt == (rnds - RW'(1)));
   end

   // Main FSM with counters and registered outputs. dout and done are
   // loaded on the edge that enters FIN so they are visible during FIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         word    <= '0;
         rnds    <= '0;
         nib_cnt <= '0;
         rnd_cnt <= '0;
         dout    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  word    <= din;
                  rnds    <= rounds;
                  nib_cnt <= '0;
                  rnd_cnt <= '0;
                  busy    <= 1'b1;
                  if (rounds == '0) begin
                     dout  <= din;
                     done  <= 1'b1;
                     state <= ST_FIN;
                  end else begin
                     state <= ST_SUB;
                  end
               end
            end
            ST_SUB: begin
               word    <= word_sub;
               nib_cnt <= nib_cnt + 2'd1;
               if (nib_cnt == 2'd3) begin
                  state <= ST_MIX;
               end
            end
            ST_MIX: begin
               word    <= word_rot;
               rnd_cnt <= rnd_cnt + RW'(1);
               nib_cnt <= '0;
               if (last_round) begin
                  dout  <= word_rot;
                  done  <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  state <= ST_SUB;
               end
            end
            ST_FIN: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule
